// File: rtl/dual_issue_stage.sv
// rtl/dual_issue_stage.sv - in-order dual-issue stage with 8-entry FIFO and busy-bit scoreboard
// Optional ISSUE_BYPASS_EN: a source cleared by this cycle's writeback is treated as ready.
`ifndef WIDTH_UOP
`define WIDTH_UOP 16
`endif
`ifndef UOP_SRC1
`define UOP_SRC1 1:0
`endif
`ifndef UOP_SRC2
`define UOP_SRC2 3:2
`endif
`ifndef UOP_TYPE
`define UOP_TYPE 6:4
`endif
`ifndef CTRL_SRC1_RF
`define CTRL_SRC1_RF 2'd1
`endif
`ifndef CTRL_SRC2_RF
`define CTRL_SRC2_RF 2'd1
`endif
`ifndef UOP_TYPE_ALU
`define UOP_TYPE_ALU 3'd0
`endif
`ifndef UOP_TYPE_MEM
`define UOP_TYPE_MEM 3'd1
`endif

module dual_issue_stage #(
  parameter int DEPTH  = 8,
  parameter int PTR_W  = 3,
  parameter int INST_W = `WIDTH_UOP + 15 + 32 + 32 + 6 + 32 + 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic              stall,
  input  logic [1:0]        in_valid,
  input  logic [INST_W-1:0] in0_inst,
  input  logic [INST_W-1:0] in1_inst,
  output logic              in_ready,
  input  logic              write_en_0,
  input  logic              write_en_1,
  input  logic [4:0]        write_addr_0,
  input  logic [4:0]        write_addr_1,
  output logic              eu0_en,
  output logic              eu1_en,
  output logic [INST_W-1:0] eu0_inst,
  output logic [INST_W-1:0] eu1_inst
);
  localparam int CNT_W   = PTR_W + 1;
  localparam int UOP_LSB = INST_W - `WIDTH_UOP;
  localparam int RD_LSB  = UOP_LSB - 5;
  localparam int RJ_LSB  = RD_LSB - 5;
  localparam int RK_LSB  = RJ_LSB - 5;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [INST_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr, r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic [31:0]       r_busy;
  logic              r_eu0_en, r_eu1_en;
  logic [INST_W-1:0] r_eu0_inst, r_eu1_inst;

  logic [INST_W-1:0] w_h0, w_h1;
  logic [31:0]       w_clr, w_set, w_src_busy;
  logic              w_push, w_iss0, w_iss1, w_h1_dep;
  logic [1:0]        w_npush, w_niss;

  function automatic logic [4:0] f_rd(input logic [INST_W-1:0] b);
    return b[RD_LSB +: 5];
  endfunction
  function automatic logic [4:0] f_rj(input logic [INST_W-1:0] b);
    return b[RJ_LSB +: 5];
  endfunction
  function automatic logic [4:0] f_rk(input logic [INST_W-1:0] b);
    return b[RK_LSB +: 5];
  endfunction
  function automatic logic [`WIDTH_UOP-1:0] f_uop(input logic [INST_W-1:0] b);
    return b[UOP_LSB +: `WIDTH_UOP];
  endfunction
  function automatic logic f_use_j(input logic [INST_W-1:0] b);
    logic [`WIDTH_UOP-1:0] u;
    u = f_uop(b);
    return u[`UOP_SRC1] == `CTRL_SRC1_RF;
  endfunction
  function automatic logic f_use_k(input logic [INST_W-1:0] b);
    logic [`WIDTH_UOP-1:0] u;
    u = f_uop(b);
    return u[`UOP_SRC2] == `CTRL_SRC2_RF;
  endfunction
  function automatic logic f_pairable(input logic [INST_W-1:0] b);
    logic [`WIDTH_UOP-1:0] u;
    u = f_uop(b);
    return (u[`UOP_TYPE] == `UOP_TYPE_ALU) || (u[`UOP_TYPE] == `UOP_TYPE_MEM);
  endfunction

  // Sources check w_src_busy (optionally bypassed); rd always checks the pre-cycle busy bits.
  function automatic logic f_ready(input logic [INST_W-1:0] b, input logic [31:0] sb,
                                   input logic [31:0] db);
    logic ok;
    ok = 1'b1;
    if (f_use_j(b) && f_rj(b) != 5'd0 && sb[f_rj(b)]) ok = 1'b0;
    if (f_use_k(b) && f_rk(b) != 5'd0 && sb[f_rk(b)]) ok = 1'b0;
    if (b[0] && f_rd(b) != 5'd0 && db[f_rd(b)]) ok = 1'b0;
    return ok;
  endfunction

  assign in_ready = (r_count <= CNT_W'(DEPTH - 2));
  assign w_push   = in_ready && (in_valid != 2'b00) && !flush;
  assign w_npush  = !w_push ? 2'd0 : (in_valid == 2'b11) ? 2'd2 : 2'd1;
  assign w_h0     = r_mem[r_rptr];
  assign w_h1     = r_mem[r_rptr + PTR_ONE];

  always_comb begin
    w_clr = '0;
    if (write_en_0) w_clr[write_addr_0] = 1'b1;
    if (write_en_1) w_clr[write_addr_1] = 1'b1;
`ifdef ISSUE_BYPASS_EN
    w_src_busy = r_busy & ~w_clr;
`else
    w_src_busy = r_busy;
`endif
    w_h1_dep = 1'b0;
    if (w_h0[0] && f_rd(w_h0) != 5'd0) begin
      if (f_use_j(w_h1) && f_rj(w_h1) == f_rd(w_h0)) w_h1_dep = 1'b1;
      if (f_use_k(w_h1) && f_rk(w_h1) == f_rd(w_h0)) w_h1_dep = 1'b1;
      if (w_h1[0] && f_rd(w_h1) == f_rd(w_h0)) w_h1_dep = 1'b1;
    end
    if (!f_pairable(w_h0)) w_h1_dep = 1'b1;
    w_iss0 = (r_count != '0) && !stall && !flush && f_ready(w_h0, w_src_busy, r_busy);
    w_iss1 = w_iss0 && (r_count >= CNT_W'(2)) && !w_h1_dep && f_ready(w_h1, w_src_busy, r_busy);
    w_niss = {1'b0, w_iss0} + {1'b0, w_iss1};
    w_set = '0;
    if (w_iss0 && w_h0[0]) w_set[f_rd(w_h0)] = 1'b1;
    if (w_iss1 && w_h1[0]) w_set[f_rd(w_h1)] = 1'b1;
    w_set[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      if (in_valid == 2'b11) begin
        r_mem[r_wptr]           <= in0_inst;
        r_mem[r_wptr + PTR_ONE] <= in1_inst;
      end else if (in_valid[0]) begin
        r_mem[r_wptr] <= in0_inst;
      end else begin
        r_mem[r_wptr] <= in1_inst;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_busy     <= '0;
      r_eu0_en   <= 1'b0;
      r_eu1_en   <= 1'b0;
      r_eu0_inst <= '0;
      r_eu1_inst <= '0;
    end else if (flush) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_busy   <= '0;
      r_eu0_en <= 1'b0;
      r_eu1_en <= 1'b0;
    end else begin
      r_wptr  <= r_wptr + PTR_W'(w_npush);
      r_rptr  <= r_rptr + PTR_W'(w_niss);
      r_count <= r_count + CNT_W'(w_npush) - CNT_W'(w_niss);
      // Set after clear: a newly issued producer outranks an older writeback.
      r_busy  <= (r_busy & ~w_clr) | w_set;
      if (!stall) begin
        r_eu0_en <= w_iss0;
        r_eu1_en <= w_iss1;
        if (w_iss0) r_eu0_inst <= w_h0;
        if (w_iss1) r_eu1_inst <= w_h1;
      end
    end
  end

  assign eu0_en   = r_eu0_en;
  assign eu1_en   = r_eu1_en;
  assign eu0_inst = r_eu0_inst;
  assign eu1_inst = r_eu1_inst;
endmodule

// File: tb/tb_dual_issue_stage.sv
// tb/tb_dual_issue_stage.sv - directed self-checking bench for dual_issue_stage
`ifndef WIDTH_UOP
`define WIDTH_UOP 16
`endif
`ifndef UOP_SRC1
`define UOP_SRC1 1:0
`endif
`ifndef UOP_SRC2
`define UOP_SRC2 3:2
`endif
`ifndef UOP_TYPE
`define UOP_TYPE 6:4
`endif
`ifndef CTRL_SRC1_RF
`define CTRL_SRC1_RF 2'd1
`endif
`ifndef CTRL_SRC2_RF
`define CTRL_SRC2_RF 2'd1
`endif

module tb_dual_issue_stage;
  localparam int W = `WIDTH_UOP + 15 + 32 + 32 + 6 + 32 + 1;

  logic         clk = 1'b0;
  logic         rstn = 1'b0, flush = 1'b0, stall = 1'b0;
  logic [1:0]   in_valid = 2'b00;
  logic [W-1:0] in0_inst = '0, in1_inst = '0;
  logic         in_ready;
  logic         write_en_0 = 1'b0, write_en_1 = 1'b0;
  logic [4:0]   write_addr_0 = '0, write_addr_1 = '0;
  logic         eu0_en, eu1_en;
  logic [W-1:0] eu0_inst, eu1_inst;

  int total = 0;
  int bad = 0;

  logic [W-1:0] a, b, br, alu8, a5, b6, c, d, f, h0, h1;
  logic [W-1:0] e [8];
  logic [W-1:0] g [5];
  logic [W-1:0] exp_inst, nxt_inst;
  int           exp_cnt;

  dual_issue_stage dut (
    .clk(clk), .rstn(rstn), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in0_inst(in0_inst), .in1_inst(in1_inst), .in_ready(in_ready),
    .write_en_0(write_en_0), .write_en_1(write_en_1),
    .write_addr_0(write_addr_0), .write_addr_1(write_addr_1),
    .eu0_en(eu0_en), .eu1_en(eu1_en), .eu0_inst(eu0_inst), .eu1_inst(eu1_inst)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk(input logic [2:0] ty, input logic s1, input logic s2,
                                      input logic [4:0] rd, input logic [4:0] rj,
                                      input logic [4:0] rk, input logic wen,
                                      input logic [31:0] pc);
    logic [`WIDTH_UOP-1:0] u;
    u = '0;
    u[`UOP_TYPE] = ty;
    u[`UOP_SRC1] = s1 ? `CTRL_SRC1_RF : 2'd0;
    u[`UOP_SRC2] = s2 ? `CTRL_SRC2_RF : 2'd0;
    return {u, rd, rj, rk, pc, pc + 32'd4, 6'd0, 32'h0, wen};
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb0(input logic [4:0] r);
    write_en_0 = 1'b1;
    write_addr_0 = r;
    tick();
    write_en_0 = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst_eu0_en", W'(eu0_en), '0);
    chk("rst_eu1_en", W'(eu1_en), '0);
    chk("rst_eu0_inst", eu0_inst, '0);
    chk("rst_eu1_inst", eu1_inst, '0);
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_count", W'(dut.r_count), '0);
    chk("rst_busy", W'(dut.r_busy), '0);
    rstn = 1'b1;

    // two independent ALU ops dual-issue one cycle after push
    a = mk(3'd0, 1'b1, 1'b0, 5'd1, 5'd2, 5'd0, 1'b1, 32'h100);
    b = mk(3'd0, 1'b1, 1'b0, 5'd3, 5'd4, 5'd0, 1'b1, 32'h104);
    in0_inst = a; in1_inst = b; in_valid = 2'b11;
    tick();
    in_valid = 2'b00;
    chk("s1_count_push", W'(dut.r_count), W'(2));
    chk("s1_latency_en0", W'(eu0_en), '0);
    tick();
    chk("s1_eu0_en", W'(eu0_en), W'(1));
    chk("s1_eu0_inst", eu0_inst, a);
    chk("s1_eu1_en", W'(eu1_en), W'(1));
    chk("s1_eu1_inst", eu1_inst, b);
    chk("s1_busy", W'(dut.r_busy), W'(32'h0000_000A));
    chk("s1_count_issue", W'(dut.r_count), '0);
    tick();
    chk("s1_idle_en0", W'(eu0_en), '0);
    chk("s1_idle_inst_hold", eu0_inst, a);
    write_en_0 = 1'b1; write_addr_0 = 5'd1;
    write_en_1 = 1'b1; write_addr_1 = 5'd3;
    tick();
    write_en_0 = 1'b0; write_en_1 = 1'b0;
    chk("s1_busy_clr", W'(dut.r_busy), '0);

    // branch at H0 prevents pairing
    br   = mk(3'd2, 1'b1, 1'b0, 5'd0, 5'd1, 5'd0, 1'b0, 32'h200);
    alu8 = mk(3'd0, 1'b0, 1'b0, 5'd8, 5'd0, 5'd0, 1'b1, 32'h204);
    in0_inst = br; in1_inst = alu8; in_valid = 2'b11;
    tick();
    in_valid = 2'b00;
    tick();
    chk("br_eu0_en", W'(eu0_en), W'(1));
    chk("br_eu0_inst", eu0_inst, br);
    chk("br_eu1_en", W'(eu1_en), '0);
    tick();
    chk("br_next_en0", W'(eu0_en), W'(1));
    chk("br_next_inst", eu0_inst, alu8);
    chk("br_eu1_hold", eu1_inst, b);
    chk("br_busy8", W'(dut.r_busy), W'(32'h0000_0100));
    wb0(5'd8);

    // RAW between slots, then wait for writeback of r5
    a5 = mk(3'd0, 1'b1, 1'b1, 5'd5, 5'd1, 5'd2, 1'b1, 32'h300);
    b6 = mk(3'd0, 1'b1, 1'b1, 5'd6, 5'd5, 5'd0, 1'b1, 32'h304);
    in0_inst = a5; in1_inst = b6; in_valid = 2'b11;
    tick();
    in_valid = 2'b00;
    tick();
    chk("raw_eu0_en", W'(eu0_en), W'(1));
    chk("raw_eu0_inst", eu0_inst, a5);
    chk("raw_eu1_blocked", W'(eu1_en), '0);
    chk("raw_busy5", W'(dut.r_busy), W'(32'h0000_0020));
    tick();
    chk("raw_wait_en0", W'(eu0_en), '0);
    wb0(5'd5);
`ifdef ISSUE_BYPASS_EN
    chk("raw_bypass_en0", W'(eu0_en), W'(1));
    chk("raw_bypass_inst", eu0_inst, b6);
    tick();
    chk("raw_after_en0", W'(eu0_en), '0);
`else
    chk("raw_wb_cycle_en0", W'(eu0_en), '0);
    tick();
    chk("raw_late_en0", W'(eu0_en), W'(1));
    chk("raw_late_inst", eu0_inst, b6);
`endif
    chk("raw_busy6", W'(dut.r_busy), W'(32'h0000_0040));
    wb0(5'd6);
    chk("raw_busy_clr", W'(dut.r_busy), '0);

    // slot1-only push, then issue r9 while r9 is written back: set wins
    c = mk(3'd0, 1'b0, 1'b0, 5'd9, 5'd0, 5'd0, 1'b1, 32'h400);
    in0_inst = mk(3'd0, 1'b0, 1'b0, 5'd31, 5'd0, 5'd0, 1'b1, 32'h999);
    in1_inst = c; in_valid = 2'b10;
    tick();
    in_valid = 2'b00;
    chk("s10_count", W'(dut.r_count), W'(1));
    wb0(5'd9);
    chk("setclr_en0", W'(eu0_en), W'(1));
    chk("setclr_inst", eu0_inst, c);
    chk("setclr_busy9", W'(dut.r_busy), W'(32'h0000_0200));
    write_en_1 = 1'b1; write_addr_1 = 5'd9;
    tick();
    write_en_1 = 1'b0;
    chk("setclr_busy_clr", W'(dut.r_busy), '0);

    // fill FIFO with consumers of busy r7
    d = mk(3'd0, 1'b0, 1'b0, 5'd7, 5'd0, 5'd0, 1'b1, 32'h500);
    in0_inst = d; in_valid = 2'b01;
    tick();
    in_valid = 2'b00;
    tick();
    chk("full_busy7", W'(dut.r_busy), W'(32'h0000_0080));
    for (int i = 0; i < 8; i++)
      e[i] = mk(3'd0, 1'b1, 1'b0, 5'(10 + i), 5'd7, 5'd0, 1'b1, 32'h600 + 32'(4 * i));
    for (int i = 0; i < 4; i++) begin
      chk("full_ready_before", W'(in_ready), W'(1));
      in0_inst = e[2*i]; in1_inst = e[2*i+1]; in_valid = 2'b11;
      tick();
    end
    chk("full_count8", W'(dut.r_count), W'(8));
    chk("full_not_ready", W'(in_ready), '0);
    in0_inst = g[0]; in1_inst = g[0];
    tick();
    in_valid = 2'b00;
    chk("full_ignored_count", W'(dut.r_count), W'(8));
    chk("full_no_issue", W'(eu0_en), '0);

    // release r7, then stall with eu0_en high
    wb0(5'd7);
    tick();
`ifdef ISSUE_BYPASS_EN
    exp_inst = e[2]; nxt_inst = e[4]; exp_cnt = 4;
`else
    exp_inst = e[0]; nxt_inst = e[2]; exp_cnt = 6;
`endif
    chk("stall_pre_en0", W'(eu0_en), W'(1));
    chk("stall_pre_inst", eu0_inst, exp_inst);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_en0", W'(eu0_en), W'(1));
      chk("stall_inst", eu0_inst, exp_inst);
      chk("stall_count", W'(dut.r_count), W'(exp_cnt));
    end
    stall = 1'b0;
    tick();
    chk("resume_en0", W'(eu0_en), W'(1));
    chk("resume_inst", eu0_inst, nxt_inst);
    chk("resume_count", W'(dut.r_count), W'(exp_cnt - 2));

    rstn = 1'b0;
    #2;
    rstn = 1'b1;
    chk("pulse_count", W'(dut.r_count), '0);

    // flush with 5 queued and busy r4
    f = mk(3'd0, 1'b0, 1'b0, 5'd4, 5'd0, 5'd0, 1'b1, 32'h700);
    for (int i = 0; i < 5; i++)
      g[i] = mk(3'd0, 1'b1, 1'b0, 5'(20 + i), 5'd4, 5'd0, 1'b1, 32'h800 + 32'(4 * i));
    in0_inst = f; in_valid = 2'b01;
    tick();
    in_valid = 2'b00;
    tick();
    in0_inst = g[0]; in1_inst = g[1]; in_valid = 2'b11;
    tick();
    in0_inst = g[2]; in1_inst = g[3];
    tick();
    in0_inst = g[4]; in_valid = 2'b01;
    tick();
    in_valid = 2'b00;
    chk("flush_pre_count", W'(dut.r_count), W'(5));
    chk("flush_pre_busy", W'(dut.r_busy), W'(32'h0000_0010));
    flush = 1'b1; stall = 1'b1; in_valid = 2'b11;
    tick();
    flush = 1'b0; stall = 1'b0;
    chk("flush_count", W'(dut.r_count), '0);
    chk("flush_busy", W'(dut.r_busy), '0);
    chk("flush_en0", W'(eu0_en), '0);
    chk("flush_en1", W'(eu1_en), '0);

    // asynchronous reset in the middle of a push cycle
    h0 = mk(3'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h900);
    h1 = mk(3'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h904);
    in0_inst = h0; in1_inst = h1; in_valid = 2'b11;
    tick();
    chk("arst_pre_count", W'(dut.r_count), W'(2));
    tick();
    chk("arst_pre_en0", W'(eu0_en), W'(1));
    chk("arst_pre_inst", eu0_inst, h0);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_en0", W'(eu0_en), '0);
    chk("arst_en1", W'(eu1_en), '0);
    chk("arst_inst0", eu0_inst, '0);
    chk("arst_count", W'(dut.r_count), '0);
    chk("arst_ready", W'(in_ready), W'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dual_issue_stage.md
Name: dual_issue_stage

Overview:
- Issue stage between decode and register-read/operand-fetch.
- Buffers decoded instructions in an 8-entry in-order FIFO and issues up to two per cycle on pipes eu0/eu1.
- A 32-entry busy-bit scoreboard blocks RAW/WAW hazards against in-flight writes and between the two issue slots.
- Drives the `eu0_*`/`eu1_*` inputs of the register-read stage.

Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 4.
- PTR_W, 3, log2(DEPTH).

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- flush  in  1  pipeline flush: empties FIFO, clears scoreboard.
- stall  in  1  downstream cannot accept: hold everything, issue nothing.
- in_valid  in  2  decode slot valid; bit0 is older.
- in0_inst  in  INST_W  decoded slot-0 bundle.
- in1_inst  in  INST_W  decoded slot-1 bundle.
- in_ready  out  1  at least 2 free entries.
- write_en_0  in  1  writeback port 0 valid.
- write_en_1  in  1  writeback port 1 valid.
- write_addr_0  in  5  writeback port 0 register.
- write_addr_1  in  5  writeback port 1 register.
- eu0_en  out  1  eu0 slot valid this cycle.
- eu1_en  out  1  eu1 slot valid this cycle.
- eu0_inst  out  INST_W  bundle to eu0.
- eu1_inst  out  INST_W  bundle to eu1.

Behaviour:
- INST_W = `WIDTH_UOP`+15+32+32+6+32+1, taken from uop.vh.
- Bundle layout, MSB to LSB: uop, rd, rj, rk, pc, pc_next, exp, imm, wen.
- Source use comes from uop fields:
  - rj is read iff `uop[UOP_SRC1]`==`CTRL_SRC1_RF`.
  - rk is read iff `uop[UOP_SRC2]`==`CTRL_SRC2_RF`.
  - r0 is never busy.
- Reset (rstn low, asynchronous):
  - FIFO empty, both pointers 0, scoreboard all 0.
  - eu0_en=eu1_en=0, eu0_inst=eu1_inst=0.
  - in_ready is combinational; it is 1 after reset.
- Push: when in_ready and in_valid!=0, write valid slots in order.
  - in_valid=2'b10 pushes slot1 alone.
  - Pushing while in_ready=0 is ignored (protocol error, no state change).
- Issue (registered outputs, 1-cycle latency FIFO head to eu*_en):
  - Head H0 issues to eu0 when: FIFO non-empty, !stall, !flush, and none of H0's used rj/rk and its rd (if wen) are busy.
  - H1 issues to eu1 only if H0 issues in the same cycle, H1 passes the same check, and none of the following hold:
    - H1 reads H0.rd with H0.wen.
    - H1.rd==H0.rd with both wen.
    - H0 uop is a branch/CSR/privileged class (`UOP_TYPE` != ALU/MEM).
  - Issue is strictly in order: if H0 blocks, nothing issues.
  - When stall=1: outputs and state hold, including eu*_en values.
  - When not issuing and not stalled: eu*_en=0 and eu*_inst holds its old value.
- Scoreboard:
  - Set busy[rd] on issue when wen and rd!=0.
  - Clear busy[write_addr_k] when write_en_k.
  - Set and clear of the same register in one cycle: set wins, because the new producer is younger.
- Pointers wrap modulo DEPTH. Count is tracked with a (PTR_W+1)-bit counter.
- Push and issue in the same cycle: count += pushes - issues. Full and empty are computed from the pre-cycle count.
- flush (synchronous, priority over push, issue and stall):
  - Next cycle: FIFO empty, scoreboard 0, eu*_en=0.
  - rstn low overrides flush.

Optional Feature:
- ISSUE_BYPASS_EN
- Defined: a source register whose busy bit is being cleared this cycle by a matching write_en_k/write_addr_k is treated as ready. The instruction may issue that cycle, relying on register-read write-port forwarding. This does not apply to the rd WAW check.
- Undefined: the busy bit must already be 0 at the start of the cycle, so the writeback-to-issue gap is one cycle longer.

Test Plan:
- Reset then push two independent ALU ops (rd=1 rj=2; rd=3 rj=4) -> next cycle eu0_en=eu1_en=1 with both bundles; busy[1], busy[3] set.
- Push add r5,r1,r2 then add r6,r5,r0 -> eu0 issues r5; r6 op stalls.
  - Without the macro: it issues the cycle after write_en_0=1, write_addr_0=5.
  - With ISSUE_BYPASS_EN: it issues in the same cycle as that write.
- Push 8 instructions all reading busy r7 -> in_ready=0 when count>6. Further pushes are ignored, and count stays 8.
- Same-cycle issue setting busy[9] and writeback clearing r9 -> busy[9]=1 afterward.
- stall=1 for 3 cycles with eu0_en=1 -> eu0_en and eu0_inst held, FIFO count unchanged; resumes on release.
- flush with 5 queued and busy[4]=1 -> next cycle FIFO empty, busy all 0, eu*_en=0.
  - Then drop rstn mid-push -> state reset immediately, asynchronously.
